// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic arithmetic engine.
// Mode/state enums, Galois tap table for 4..16-bit LFSRs, stream length helper.
package sc_pkg;

  localparam int SC_MIN_W = 4;
  localparam int SC_MAX_W = 16;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_SADD = 2'd1,
    MODE_PASS = 2'd2,
    MODE_BMUL = 2'd3
  } sc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sc_state_e;

  // Right-shifting Galois masks; each gives a period of 2^w-1.
  function automatic logic [SC_MAX_W-1:0] sc_taps(input int w);
    case (w)
      4:       return 16'h0009;
      5:       return 16'h0012;
      6:       return 16'h0021;
      7:       return 16'h0041;
      8:       return 16'h008E;
      9:       return 16'h0108;
      10:      return 16'h0204;
      11:      return 16'h0402;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h4001;
      16:      return 16'h8016;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int sc_len(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Galois LFSR stream source; reloads its seed on load and recovers from the
// all-zero lock-up state by forcing the seed.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [SC_MAX_W-1:0] TAPS_FULL = sc_taps(WIDTH);
  localparam logic [WIDTH-1:0]    TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  assign w_next = {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_state <= SEED;
    else if (load)           r_state <= SEED;
    else if (r_state == '0)  r_state <= SEED;
    else if (step)           r_state <= w_next;
  end

  assign state = r_state;

endmodule

// File: rtl/sc_arith_engine.sv
// Stochastic-computing arithmetic core: CHANNELS lanes share two LFSR stream
// generators; optional bipolar multiply is enabled with SC_BIPOLAR_EN.
module sc_arith_engine
  import sc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int SEED_A   = 1,
  parameter int SEED_B   = 'h5A
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [1:0]                i_mode,
  input  logic [CHANNELS*WIDTH-1:0] i_op_a,
  input  logic [CHANNELS*WIDTH-1:0] i_op_b,
  output logic                      o_busy,
  output logic [CHANNELS*WIDTH-1:0] o_res,
  output logic                      o_res_valid,
  input  logic                      i_res_ready
`ifdef SC_BIPOLAR_EN
  ,
  output logic                      o_bipolar_flag
`endif
);

  localparam int               L     = sc_len(WIDTH);
  localparam int               LM1   = L - 1;
  localparam logic [WIDTH-1:0] L_W   = L[WIDTH-1:0];
  localparam logic [WIDTH:0]   L_C   = L[WIDTH:0];
  localparam logic [WIDTH-1:0] LAST  = LM1[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SDA_W = SEED_A[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SDB_W = SEED_B[WIDTH-1:0];

  sc_state_e                       r_state, w_state_nxt;
  sc_mode_e                        r_mode;
  logic [CHANNELS-1:0][WIDTH-1:0]  r_a, r_b, r_res;
  logic [CHANNELS-1:0][WIDTH:0]    r_cnt, w_sum;
  logic [CHANNELS-1:0][WIDTH-1:0]  w_sat;
  logic [CHANNELS-1:0]             w_sa, w_sb, w_bit;
  logic [WIDTH-1:0]                r_cyc;
  logic                            r_valid;
  logic                            w_load, w_run, w_done, w_accept;
  logic [WIDTH-1:0]                w_lfsr_a, w_lfsr_b, w_lfsr_c;
  logic                            w_sel;

  sc_lfsr #(.WIDTH(WIDTH), .SEED(SDA_W)) u_lfsr_a (
    .clk(clk), .rst(rst), .load(w_load), .step(w_run), .state(w_lfsr_a)
  );

  sc_lfsr #(.WIDTH(WIDTH), .SEED(SDB_W)) u_lfsr_b (
    .clk(clk), .rst(rst), .load(w_load), .step(w_run), .state(w_lfsr_b)
  );

  // LFSR C is A bit-reversed; its msb is therefore A's lsb.
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign w_lfsr_c[g] = w_lfsr_a[WIDTH-1-g];
  end
  assign w_sel = w_lfsr_c[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_run       = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_cyc == LAST) begin
          w_done      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: if (r_valid && i_res_ready) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sa  = '0;
    w_sb  = '0;
    w_bit = '0;
    w_sum = '0;
    w_sat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sa[i] = (w_lfsr_a <= r_a[i]);
      w_sb[i] = (w_lfsr_b <= r_b[i]);
      case (r_mode)
        MODE_MUL:  w_bit[i] = w_sa[i] & w_sb[i];
        MODE_SADD: w_bit[i] = w_sel ? w_sb[i] : w_sa[i];
`ifdef SC_BIPOLAR_EN
        MODE_BMUL: w_bit[i] = ~(w_sa[i] ^ w_sb[i]);
`endif
        default:   w_bit[i] = w_sa[i];
      endcase
      w_sum[i] = r_cnt[i] + {{WIDTH{1'b0}}, w_bit[i]};
      w_sat[i] = (w_sum[i] > L_C) ? L_W : w_sum[i][WIDTH-1:0];
    end
  end

  // The final stream bit is folded straight into the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= MODE_MUL;
      r_cnt   <= '0;
      r_cyc   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_a    <= i_op_a;
        r_b    <= i_op_b;
        r_mode <= sc_mode_e'(i_mode);
        r_cnt  <= '0;
        r_cyc  <= '0;
      end
      if (w_run) begin
        r_cyc <= r_cyc + 1'b1;
        r_cnt <= w_sum;
      end
      if (w_done) begin
        r_res   <= w_sat;
        r_valid <= 1'b1;
      end
      if (w_accept) r_valid <= 1'b0;
    end
  end

`ifdef SC_BIPOLAR_EN
  logic r_flag;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_flag <= 1'b0;
    else if (w_load) r_flag <= 1'b0;
    else if (w_done) r_flag <= (r_mode == MODE_BMUL);
  end
  assign o_bipolar_flag = r_flag;
`endif

  assign o_busy      = (r_state == ST_RUN);
  assign o_res       = r_res;
  assign o_res_valid = r_valid;

endmodule

// File: doc/sc_arith_engine.md
Name: sc_arith_engine

Overview:
- Parametrised stochastic-computing arithmetic core; next generation of the team's fixed 8-bit stochastic add/multiply tile.
- Converts binary operands to unipolar bitstreams using shared LFSRs and comparators.
- Applies a per-run operation (multiply, scaled add, pass) over CHANNELS independent lanes, then counts ones back to binary.
- Sits behind the top-level pin wrapper; result is presented through a valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..16. Stream length L = 2^WIDTH - 1 cycles.
- CHANNELS, 2, number of independent lanes sharing the stream generators.
- SEED_A, 1, non-zero reset seed of LFSR A (truncated to WIDTH).
- SEED_B, 'h5A, non-zero reset seed of LFSR B (truncated to WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a run
- mode  in  2  0=MUL (AND), 1=SADD (MUX, select=LFSR C msb), 2=PASS_A, 3=BMUL (XNOR, see optional feature)
- op_a  in  CHANNELS*WIDTH  operand A per lane; lane i at [i*WIDTH +: WIDTH]
- op_b  in  CHANNELS*WIDTH  operand B per lane; same packing
- busy  out  1  run in progress
- res  out  CHANNELS*WIDTH  result per lane; same packing
- res_valid  out  1  result held valid
- res_ready  in  1  consumer accepts result

Behaviour:
- Reset, asynchronous: state IDLE; busy=0; res_valid=0; res=0; LFSRs reload their seeds; counters=0.
- Reset asserted mid-run or while a result is pending discards all work.
- Required FSM states: IDLE, RUN, HOLD.
- IDLE, start=1:
  - Latch op_a, op_b and mode.
  - Clear per-lane ones-counters (WIDTH+1 bits wide).
  - Reload LFSRs to their seeds.
  - Go to RUN; busy=1 from the next cycle.
- start while RUN or HOLD: ignored; no effect on latched operands.
- RUN, each cycle:
  - Stream bits: sa_i = (lfsrA <= A_i), sb_i = (lfsrB <= B_i).
  - Each LFSR visits every value 1..L exactly once per run, so sa_i is 1 on exactly A_i cycles.
  - Output bit per mode:
    - MUL: sa&sb.
    - SADD: sel ? sb : sa, where sel is the msb of LFSR C (the bit-reversed LFSR A state).
    - PASS_A: sa.
  - Output bit increments the lane counter; all LFSRs step.
- RUN lasts exactly L cycles. On the cycle after the last stream bit:
  - res_i = counter_i saturated to L.
  - res_valid=1, busy=0; go to HOLD.
- Latency from the start cycle to res_valid high: L+1 cycles.
- HOLD: res and res_valid stable until res_valid & res_ready. On that cycle go to IDLE; res_valid=0 next cycle, res retains its value.
- start in the same cycle as the accepting handshake is ignored.
- LFSR: Galois, maximal-length taps per WIDTH from the package. The all-zero state is unreachable; if entered, force to seed next cycle.
- Guaranteed exact results:
  - A=0 → 0 in every mode.
  - MUL with A=L → B.
  - SADD with A=B → A.
  - PASS_A → A.
  - Other results are approximate (correlated streams).
- Mode 3 without the optional feature behaves as PASS_A.

Optional Feature:
- Macro: SC_BIPOLAR_EN.
- Defined:
  - Mode 3 = BMUL; output bit sa XNOR sb, counted as normal.
  - res is a bipolar-encoded count: value v represents (2v-L)/L.
  - Adds sticky output bipolar_flag (1 bit, reset 0), set when a BMUL run completes and cleared on the next start.
- Undefined: mode 3 aliases PASS_A; no bipolar_flag port.

Decomposition:
- Package sc_pkg:
  - mode enum (MUL, SADD, PASS_A, BMUL).
  - FSM state enum.
  - Function returning the Galois tap mask for WIDTH 4..16.
  - Constant for stream length computation.
- Sub-module sc_lfsr (parameters WIDTH and SEED; ports clk, rst, load, step, state), instantiated twice (A and B).
- LFSR C is a wiring permutation of A; it has no register.

Test Plan:
- WIDTH=8, CHANNELS=2; reset mid-run after 100 cycles → busy=0, res_valid=0, res=0 immediately. A new start then completes in 256 cycles.
- MUL, lane0 A=255 B=77, lane1 A=0 B=200 → after 256 cycles res_valid=1, lane0=77, lane1=0.
- SADD, A=B=120 on both lanes → both 120.
- PASS_A A=33; res_ready held 0 for 20 cycles → res stable and valid. Start pulses during HOLD are ignored. Accepted on ready=1; res_valid drops the next cycle.
- MUL A=128 B=128 over WIDTH=8 and WIDTH=12 → result within ±10% of A*B/L. Also check busy high for exactly L cycles.
- SC_BIPOLAR_EN: BMUL A=B=255 → 255 and bipolar_flag=1. Without the macro, mode 3 A=50 → 50.
